// File: rtl/mult_hilo_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_hilo_unit_pkg
//   Shared definitions for the HI/LO multiplier and the control unit that
//   drives it: default operand width, multiplier FSM state encoding and the
//   R-type funct codes that select MULT/MULTU/MFHI/MFLO.
// ---------------------------------------------------------------------------
package mult_hilo_unit_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } mult_state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

endpackage

// File: rtl/mult_hilo_unit.sv
// ---------------------------------------------------------------------------
// mult_hilo_unit
//   Multi-cycle radix-2 add-shift multiplier owning the architectural HI/LO
//   registers. Signed operands are multiplied as magnitudes and the product
//   is negated in a final SIGN cycle when the operand signs differ.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_mult  begin a multiply (accepted only when idle)
//   mult_sign   1 = signed (MULT), 0 = unsigned (MULTU); sampled with start
//   operand_a   rs value; sampled with start
//   operand_b   rt value; sampled with start
//   read_hilo   MFHI/MFLO is in EX this cycle
//   hi, lo      HI / LO registers
//   busy        multiply in flight
//   done        one-cycle pulse after HI/LO update
//   stall       busy & (read_hilo | start_mult), combinational
// ---------------------------------------------------------------------------
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             read_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    // Magnitude of a possibly-signed operand. The most negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic                   is_signed);
        magnitude = (is_signed && x[WIDTH-1]) ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
        negate = ~x + (2*WIDTH)'(1);
    endfunction

    mult_state_t        state, state_nxt;
    logic [WIDTH-1:0]   mcand;      // multiplicand magnitude
    logic [WIDTH-1:0]   mplr;       // multiplier magnitude, consumed LSB first
    logic [2*WIDTH-1:0] acc;        // product accumulator
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic [WIDTH:0]     sum;        // carry kept in the extra bit

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    assign busy  = (state != IDLE);
    assign stall = busy & (read_hilo | start_mult);
    assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, mcand} & {(WIDTH+1){mplr[0]}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_mult) state_nxt = CALC;
            CALC:    if (cnt == CNT_LAST) state_nxt = SIGN;
            SIGN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                // Capture: operand magnitudes and result sign
                IDLE: begin
                    if (start_mult) begin
                        mcand <= magnitude(operand_a, mult_sign);
                        mplr  <= magnitude(operand_b, mult_sign);
                        neg   <= mult_sign & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                // Add-shift: one multiplier bit per cycle
                CALC: begin
                    acc  <= {sum, acc[WIDTH-1:1]};
                    mplr <= mplr >> 1;
                    cnt  <= cnt + CNT_W'(1);
                end
                // Sign fix-up and HI/LO commit
                SIGN: begin
                    {hi, lo} <= neg ? negate(acc) : acc;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_hilo_unit
//   Directed self-checking bench for mult_hilo_unit. Inputs are driven on the
//   falling edge; outputs are sampled on the falling edge (or #1 after it).
// ---------------------------------------------------------------------------
module tb_mult_hilo_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start_mult;
    logic         mult_sign;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         read_hilo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    int n_cmp = 0;
    int n_bad = 0;

    mult_hilo_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_mult(start_mult),
        .mult_sign (mult_sign),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .read_hilo (read_hilo),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch a multiply from the current (falling-edge) time and wait until
    // busy drops. Returns the number of falling edges seen with busy high and
    // whether done was high when busy dropped.
    task automatic run_mult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int nbusy, output logic saw_done);
        start_mult = 1'b1;
        mult_sign  = s;
        operand_a  = a;
        operand_b  = b;
        @(negedge clk);
        start_mult = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            @(negedge clk);
        end
        saw_done = done;
    endtask

    int   nb;
    logic dn;
    logic stall_ok;

    initial begin
        rst_n      = 1'b0;
        start_mult = 1'b0;
        mult_sign  = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        read_hilo  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_busy", {62'h0, busy, done}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_hilo", {hi, lo}, 64'h0);
        chk("post_rst_ctl", {61'h0, busy, done, stall}, 64'h0);

        // Unsigned max * max
        run_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, dn);
        chk("umax_busy_cycles", 64'(nb), 64'd33);
        chk("umax_done", {63'h0, dn}, 64'h1);
        chk("umax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        chk("umax_done_one_cycle", {63'h0, done}, 64'h0);

        // Signed -3 * 7
        run_mult(1'b1, 32'hFFFF_FFFD, 32'd7, nb, dn);
        chk("s_m3x7_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("s_m3x7_done", {63'h0, dn}, 64'h1);

        // Back-to-back: start in the same cycle as done; unsigned same operands
        run_mult(1'b0, 32'hFFFF_FFFD, 32'd7, nb, dn);
        chk("b2b_busy_cycles", 64'(nb), 64'd33);
        chk("u_m3x7_hilo", {hi, lo}, 64'h0000_0006_FFFF_FFEB);

        // Signed corners
        @(negedge clk);
        run_mult(1'b1, 32'h8000_0000, 32'h8000_0000, nb, dn);
        chk("s_min_sq_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
        @(negedge clk);
        run_mult(1'b1, 32'h8000_0000, 32'd1, nb, dn);
        chk("s_min_x1_hilo", {hi, lo}, 64'hFFFF_FFFF_8000_0000);

        // Hazard: read_hilo from cycle 5, ignored second start at cycle 10
        @(negedge clk);
        start_mult = 1'b1;
        mult_sign  = 1'b0;
        operand_a  = 32'd6;
        operand_b  = 32'd7;
        @(negedge clk);
        start_mult = 1'b0;
        stall_ok   = 1'b1;
        for (int c = 1; c < 60; c++) begin
            read_hilo  = (c >= 5);
            start_mult = (c == 10);
            operand_a  = 32'd100;
            operand_b  = 32'd100;
            #1;
            if (!busy) break;
            if (c == 10) chk("hz_stall_on_start", {63'h0, stall}, 64'h1);
            if (c == 20) chk("hz_hilo_hold", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
            if (c >= 5 && !stall) stall_ok = 1'b0;
            if (c < 5 && stall) stall_ok = 1'b0;
            @(negedge clk);
        end
        chk("hz_stall_window", {63'h0, stall_ok}, 64'h1);
        chk("hz_idle_stall", {62'h0, busy, stall}, 64'h0);
        chk("hz_done", {63'h0, done}, 64'h1);
        chk("hz_hilo", {hi, lo}, 64'd42);
        start_mult = 1'b0;
        read_hilo  = 1'b0;
        repeat (3) @(negedge clk);
        chk("hz_second_ignored_busy", {63'h0, busy}, 64'h0);
        chk("hz_second_ignored_hilo", {hi, lo}, 64'd42);

        // Asynchronous reset mid-operation
        start_mult = 1'b1;
        mult_sign  = 1'b0;
        operand_a  = 32'd9;
        operand_b  = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hilo", {hi, lo}, 64'h0);
        chk("arst_ctl", {62'h0, busy, done}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_mult(1'b0, 32'd4, 32'd5, nb, dn);
        chk("post_arst_busy_cycles", 64'(nb), 64'd33);
        chk("post_arst_hilo", {hi, lo}, 64'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
